tick_gen_multi: RTL and testbench

- Multi-channel programmable tick generator. Successor to the single-output, two-mode system-clock divider.
- Produces NUM_CH independent one-cycle enable ticks plus a derived square wave per channel, e.g. channel 0 for the 1 s timer base and channel 1 for the 7-segment scan.
- Divisors are runtime-writable through a simple strobe/ack port and take effect glitch-free at the next wrap.
- Sits between the board clock and the timer/display logic. Outputs are clock enables, not clocks.

---
 rtl/tick_gen_pkg.sv | 27 ++
 rtl/tick_gen_multi_if.sv | 14 +
 rtl/tick_gen_ch.sv | 78 +++++++
 rtl/tick_gen_multi.sv | 60 ++++++
 tb/tb_tick_gen_multi.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Default divisors target a 20 MHz board clock: 1 s timer base and 7-segment scan.
package tick_gen_pkg;

    localparam int CNT_W_DEF = 25;
    localparam int SEC_DIV   = 20000000;
    localparam int SEG_DIV   = 1000;

    localparam int MAX_CNT_W = 32;
    localparam int MAX_VEC_W = 256;

    // Extract channel ch (w bits wide) from a packed reset-divisor vector.
    function automatic logic [MAX_CNT_W-1:0] div_of(input logic [MAX_VEC_W-1:0] vec,
                                                     input int ch, input int w);
        logic [MAX_CNT_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_CNT_W; b++) begin
            if (b < w) begin
                r[b] = vec[ch*w + b];
            end else begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Divisor configuration port: single-cycle write strobe with ack/err pulse response.
interface tick_gen_multi_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 25
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (output cfg_wr, cfg_ch, cfg_div, input cfg_ack, cfg_err);
    modport slave  (input cfg_wr, cfg_ch, cfg_div, output cfg_ack, cfg_err);
endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: wrap counter, registered tick/square outputs and a
// pending divisor that is swapped in only at a wrap, hold or restart.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] div_active_r;
    logic [CNT_W-1:0] div_pend_r;
    logic             pend_r;
    logic             tick_r;
    logic             sq_r;
    logic [CNT_W-1:0] eff_div_s;
    logic             wrap_s;
    logic             apply_s;

    // Divisors 0 and 1 both mean "tick every enabled cycle".
    assign eff_div_s = (div_active_r < CNT_W'(2)) ? CNT_W'(1) : div_active_r;
    assign wrap_s    = (cnt_r >= (eff_div_s - CNT_W'(1)));
    assign apply_s   = pend_r & (sync_clr | ~en | wrap_s);

    // Counter, tick and square-wave state.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
            sq_r   <= 1'b0;
        end else if (sync_clr) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
            sq_r   <= 1'b0;
        end else if (!en) begin
            tick_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
            sq_r   <= ~sq_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    // Divisor update: apply uses pre-edge pend, so a same-edge write waits for the next apply point.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            div_active_r <= DIV_RST;
            div_pend_r   <= '0;
            pend_r       <= 1'b0;
        end else begin
            if (apply_s) begin
                div_active_r <= div_pend_r;
            end
            if (wr_en) begin
                div_pend_r <= wr_div;
                pend_r     <= 1'b1;
            end else if (apply_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    assign tick = tick_r;
    assign sq   = sq_r;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: config decode, ack/err pulses
// and per-channel write-enable fan-out around NUM_CH tick_gen_ch instances.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int                      NUM_CH    = 2,
    parameter int                      CNT_W     = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_RESET = {CNT_W'(SEG_DIV), CNT_W'(SEC_DIV)}
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    tick_gen_multi_if.slave   cfg,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              ch_ok_s;
    logic [NUM_CH-1:0] wr_en_s;
    logic              ack_r;
    logic              err_r;

    assign ch_ok_s = (32'(cfg.cfg_ch) < 32'(NUM_CH));

    // Write accepted/rejected pulses, visible the cycle after the strobe.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= cfg.cfg_wr & ch_ok_s;
            err_r <= cfg.cfg_wr & ~ch_ok_s;
        end
    end

    assign cfg.cfg_ack = ack_r;
    assign cfg.cfg_err = err_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_en_s[g] = cfg.cfg_wr & ch_ok_s & (cfg.cfg_ch == CH_W'(g));

        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (CNT_W'(div_of(MAX_VEC_W'(DIV_RESET), g, CNT_W)))
        ) u_ch (
            .in_clk   (in_clk),
            .in_rst_n (in_rst_n),
            .en       (en[g]),
            .sync_clr (sync_clr),
            .wr_en    (wr_en_s[g]),
            .wr_div   (cfg.cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench: directed scenarios plus random traffic against an
// integer behavioural model; a second single-channel build covers cfg_err.
module tb_tick_gen_multi;

    logic       in_clk = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic       sync_clr;
    logic [1:0] tick, sq;
    logic       en2, sync_clr2;
    logic [0:0] tick2, sq2;

    tick_gen_multi_if #(.CH_W(1), .CNT_W(8)) cfg_if ();
    tick_gen_multi_if #(.CH_W(1), .CNT_W(8)) cfg2_if ();

    tick_gen_multi #(.NUM_CH(2), .CNT_W(8), .DIV_RESET({8'd3, 8'd5})) dut (
        .in_clk(in_clk), .in_rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .cfg(cfg_if), .tick(tick), .sq(sq));

    tick_gen_multi #(.NUM_CH(1), .CNT_W(8), .DIV_RESET(8'd5)) dut2 (
        .in_clk(in_clk), .in_rst_n(rst_n), .en(en2), .sync_clr(sync_clr2),
        .cfg(cfg2_if), .tick(tick2), .sq(sq2));

    always #5 in_clk = ~in_clk;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Reference model: integer enabled-cycle counters and pending divisors.
    int   m_cnt[2], m_div[2], m_pdiv[2];
    bit   m_pend[2];
    logic [1:0] m_tick, m_sq;
    logic m_ack, m_err;
    int   k2;
    logic m_err2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div[0] = 5; m_div[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pdiv[i] = 0; m_pend[i] = 0;
        end
        m_tick = 2'b00; m_sq = 2'b00; m_ack = 1'b0; m_err = 1'b0;
        k2 = 0; m_err2 = 1'b0;
    endtask

    task automatic model_step();
        int period;
        for (int i = 0; i < 2; i++) begin
            period = (m_div[i] < 2) ? 1 : m_div[i];
            if (sync_clr) begin
                m_cnt[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
                if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
            end else if (!en[i]) begin
                m_tick[i] = 1'b0;
                if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
            end else if (m_cnt[i] + 1 >= period) begin
                m_cnt[i] = 0; m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
                if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
            end else begin
                m_cnt[i]++; m_tick[i] = 1'b0;
            end
            if (cfg_if.cfg_wr && cfg_if.cfg_ch == 1'(i)) begin
                m_pdiv[i] = int'(cfg_if.cfg_div); m_pend[i] = 1;
            end
        end
        m_ack = cfg_if.cfg_wr;
        m_err = 1'b0;
        k2++;
        m_err2 = cfg2_if.cfg_wr;
    endtask

    task automatic cyc();
        @(posedge in_clk);
        model_step();
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("sq", 32'(sq), 32'(m_sq));
        chk("cfg_ack", 32'(cfg_if.cfg_ack), 32'(m_ack));
        chk("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
        chk("tick2", 32'(tick2), 32'((k2 % 5) == 0));
        chk("sq2", 32'(sq2), 32'((k2 / 5) % 2));
        chk("cfg_err2", 32'(cfg2_if.cfg_err), 32'(m_err2));
        chk("cfg_ack2", 32'(cfg2_if.cfg_ack), 32'h0);
        cfg_if.cfg_wr = 1'b0;
        cfg2_if.cfg_wr = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic write_cfg(input logic ch, input logic [7:0] div);
        cfg_if.cfg_wr = 1'b1; cfg_if.cfg_ch = ch; cfg_if.cfg_div = div;
        cyc();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cyc();
    endtask

    task automatic wait_cnt0(input int target);
        for (int g = 0; g < 20 && m_cnt[0] != target; g++) cyc();
        chk("reach_cnt0", 32'(m_cnt[0]), 32'(target));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 2'b00; sync_clr = 1'b0;
        en2 = 1'b1; sync_clr2 = 1'b0;
        cfg_if.cfg_wr = 1'b0; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_div = 8'd0;
        cfg2_if.cfg_wr = 1'b0; cfg2_if.cfg_ch = 1'b1; cfg2_if.cfg_div = 8'd0;
        model_reset();
        #3;
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_ack_err", 32'({cfg_if.cfg_ack, cfg_if.cfg_err}), 32'h0);
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        rst_n = 1'b1; en = 2'b11;

        // First ch0 tick lands on the 5th enabled edge.
        n = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(); n++;
            if (tick[0]) break;
        end
        chk("first_tick0_edge", 32'(n), 32'd5);
        run(25);

        // Divisor 2 written at cnt=1: old period finishes, then every 2 cycles.
        wait_cnt0(1);
        write_cfg(1'b0, 8'd2);
        run(16);

        // ch1 divisor 0 then 1: tick held high, sq toggles each cycle.
        write_cfg(1'b1, 8'd0);
        run(8);
        write_cfg(1'b1, 8'd1);
        run(8);
        chk("tick1_held", 32'(tick[1]), 32'h1);

        // Back to a longer ch0 period, then hold en[0] at cnt=2 for 4 cycles.
        write_cfg(1'b0, 8'd6);
        run(10);
        wait_cnt0(2);
        en[0] = 1'b0;
        run(4);
        en[0] = 1'b1;
        run(10);

        // Pending divisor 4 with cnt=3, then sync_clr.
        wait_cnt0(2);
        write_cfg(1'b0, 8'd4);
        chk("pre_clr_cnt0", 32'(m_cnt[0]), 32'd3);
        sync_clr = 1'b1;
        cyc();
        chk("clr_sq", 32'(sq), 32'h0);
        run(12);

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            en = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                cfg_if.cfg_wr = 1'b1;
                cfg_if.cfg_ch = 1'($urandom_range(0, 1));
                cfg_if.cfg_div = 8'($urandom_range(0, 9));
            end
            sync_clr = ($urandom_range(0, 24) == 0);
            cyc();
        end

        // Async reset mid-count while tick[1] is held high.
        en = 2'b11;
        write_cfg(1'b1, 8'd1);
        run(12);
        @(posedge in_clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_sq", 32'(sq), 32'h0);
        chk("async_rst_tick2", 32'(tick2), 32'h0);
        @(posedge in_clk);
        @(negedge in_clk);
        rst_n = 1'b1;
        run(15);

        // Out-of-range write on the single-channel build.
        cfg2_if.cfg_wr = 1'b1; cfg2_if.cfg_ch = 1'b1; cfg2_if.cfg_div = 8'd2;
        cyc();
        chk("err2_pulse", 32'(cfg2_if.cfg_err), 32'h1);
        run(14);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
